// File: rtl/sync_pkg.sv
// Shared widths, thresholds and state encodings for the sync decoder.
package sync_pkg;

  localparam int unsigned HW          = 9;
  localparam int unsigned VW          = 11;
  localparam int unsigned PAL_THRESH  = 287;
  localparam int unsigned LOCK_FRAMES = 2;

  typedef enum logic {
    FIELD_SHORT = 1'b0,
    FIELD_LONG  = 1'b1
  } field_e;

  typedef enum logic {
    V_IDLE = 1'b0,
    V_PEND = 1'b1
  } vstate_e;

endpackage

// File: rtl/sync_edge.sv
// Falling-edge detector for an active-low sync input; the registered copy
// resets high so a high input at reset release produces no edge.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sync_i,
  output logic fall_c_o
);

  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 1'b1;
    else       sync_q <= sync_i;
  end

  assign fall_c_o = sync_q & ~sync_i;

endmodule

// File: rtl/sync_decoder.sv
// Recovers line/frame timing from _hsync/_vsync, measures line and frame
// length, classifies fields and regenerates beam counters and strobes.
module sync_decoder
  import sync_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          _hsync,
  input  logic          _vsync,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic [HW-1:0] htotal_m,
  output logic [VW-1:0] vtotal_m,
  output logic          lof,
  output logic          interlaced,
  output logic          pal,
  output logic          locked,
  output logic          sol,
  output logic          sof,
  output logic          err
);

  localparam int unsigned CW = $clog2(LOCK_FRAMES + 1);
  localparam logic [HW-1:0] HMAX = '1;
  localparam logic [VW-1:0] VMAX = '1;

  logic hf, vf;

  sync_edge u_hedge (.clk(clk), .reset(reset), .sync_i(_hsync), .fall_c_o(hf));
  sync_edge u_vedge (.clk(clk), .reset(reset), .sync_i(_vsync), .fall_c_o(vf));

  logic [HW-1:0] hcnt_q, hcnt_d, htotal_q, htotal_d;
  logic [VW-1:0] vcnt_q, vcnt_d, vtotal_q, vtotal_d;
  logic          lof_q, lof_d, il_q, il_d, pal_q, pal_d, locked_q, locked_d;
  logic          sol_q, sol_d, sof_q, sof_d, err_q, err_d;
  logic          dirty_q, dirty_d;
  logic [CW-1:0] clean_q, clean_d;
  vstate_e       vstate_q, vstate_d;
  field_e        pend_q, pend_d;

  logic          fs, hchg, fault, new_lof;
  field_e        fs_field;

  // Long-field window: vsync fall between 1/4 and 3/4 of the measured line
  logic [HW+1:0] tot3, win_lo, win_hi;
  logic          in_win;
  assign tot3   = {2'b00, htotal_q} + {1'b0, htotal_q, 1'b0};
  assign win_lo = {2'b00, htotal_q >> 2};
  assign win_hi = tot3 >> 2;
  assign in_win = ({2'b00, hcnt_q} >= win_lo) && ({2'b00, hcnt_q} <= win_hi);

  always_comb begin
    hcnt_d   = hcnt_q;
    htotal_d = htotal_q;
    vcnt_d   = vcnt_q;
    vtotal_d = vtotal_q;
    lof_d    = lof_q;
    il_d     = il_q;
    pal_d    = pal_q;
    locked_d = locked_q;
    vstate_d = vstate_q;
    pend_d   = pend_q;
    dirty_d  = dirty_q;
    clean_d  = clean_q;
    sol_d    = hf;
    sof_d    = 1'b0;
    err_d    = 1'b0;
    fs       = 1'b0;
    fs_field = FIELD_SHORT;
    hchg     = 1'b0;
    fault    = 1'b0;
    new_lof  = 1'b0;

    if (hf) begin
      htotal_d = hcnt_q;
      hcnt_d   = '0;
      hchg     = (hcnt_q != htotal_q);
    end else if (hcnt_q != HMAX) begin
      hcnt_d = hcnt_q + HW'(1);
      if (hcnt_q == HMAX - HW'(1)) err_d = 1'b1;
    end

    // Field classification; a long field defers the frame start to the next hf
    if (vf) begin
      if (vstate_q == V_PEND) err_d = 1'b1;
      if (hf) begin
        fs       = 1'b1;
        fs_field = FIELD_SHORT;
        vstate_d = V_IDLE;
      end else begin
        vstate_d = V_PEND;
        pend_d   = in_win ? FIELD_LONG : FIELD_SHORT;
      end
    end else if (hf && (vstate_q == V_PEND)) begin
      fs       = 1'b1;
      fs_field = pend_q;
      vstate_d = V_IDLE;
    end

    if (fs) begin
      new_lof  = (fs_field == FIELD_LONG);
      vtotal_d = vcnt_q;
      vcnt_d   = '0;
      lof_d    = new_lof;
      il_d     = new_lof ^ lof_q;
      pal_d    = (vcnt_q >= VW'(PAL_THRESH));
      sof_d    = 1'b1;
    end else if (hf && (vcnt_q != VMAX)) begin
      vcnt_d = vcnt_q + VW'(1);
      if (vcnt_q == VMAX - VW'(1)) err_d = 1'b1;
    end

    // Faults at a frame-start hf belong to the frame that just ended
    fault = err_d | hchg;
    if (fault) locked_d = 1'b0;
    if (fs) begin
      dirty_d = 1'b0;
      if (dirty_q || fault) begin
        clean_d = '0;
      end else begin
        if (clean_q != CW'(LOCK_FRAMES)) clean_d = clean_q + CW'(1);
        if (clean_q >= CW'(LOCK_FRAMES - 1)) locked_d = 1'b1;
      end
    end else if (fault) begin
      dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q   <= '0;
      htotal_q <= '0;
      vcnt_q   <= '0;
      vtotal_q <= '0;
      lof_q    <= 1'b0;
      il_q     <= 1'b0;
      pal_q    <= 1'b0;
      locked_q <= 1'b0;
      sol_q    <= 1'b0;
      sof_q    <= 1'b0;
      err_q    <= 1'b0;
      dirty_q  <= 1'b0;
      clean_q  <= '0;
      vstate_q <= V_IDLE;
      pend_q   <= FIELD_SHORT;
    end else begin
      hcnt_q   <= hcnt_d;
      htotal_q <= htotal_d;
      vcnt_q   <= vcnt_d;
      vtotal_q <= vtotal_d;
      lof_q    <= lof_d;
      il_q     <= il_d;
      pal_q    <= pal_d;
      locked_q <= locked_d;
      sol_q    <= sol_d;
      sof_q    <= sof_d;
      err_q    <= err_d;
      dirty_q  <= dirty_d;
      clean_q  <= clean_d;
      vstate_q <= vstate_d;
      pend_q   <= pend_d;
    end
  end

  assign hcnt       = hcnt_q;
  assign vcnt       = vcnt_q;
  assign htotal_m   = htotal_q;
  assign vtotal_m   = vtotal_q;
  assign lof        = lof_q;
  assign interlaced = il_q;
  assign pal        = pal_q;
  assign locked     = locked_q;
  assign sol        = sol_q;
  assign sof        = sof_q;
  assign err        = err_q;

endmodule
